// File: rtl/hex_pkg.sv
// hex_pkg: shared FSM encoding, default widths and counter sizing for the hex datapaths
package hex_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;
    localparam int DW_DEF = 16;
    localparam int VW_DEF = 8;
    function automatic int cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction
endpackage

// File: rtl/hex_divider_if.sv
// hex_divider_if: control/operand/result bundle between a requester (master) and the divider (slave)
//   enable, start, in_1 (dividend), in_2 (divisor)          : master -> slave
//   quotient, remainder, div_by_zero, busy, done            : slave -> master
interface hex_divider_if #(
    parameter int DW = 16,
    parameter int VW = 8
);
    logic          enable;
    logic          start;
    logic [DW-1:0] in_1;
    logic [VW-1:0] in_2;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          busy;
    logic          done;
    modport master (
        output enable, start, in_1, in_2,
        input  quotient, remainder, div_by_zero, busy, done
    );
    modport slave (
        input  enable, start, in_1, in_2,
        output quotient, remainder, div_by_zero, busy, done
    );
endinterface

// File: rtl/hex_divider_div_step.sv
// div_step: one combinational radix-2 restoring division step
//   prem      : partial remainder entering the step
//   bit_in    : next dividend bit shifted into the partial remainder
//   divisor   : divisor
//   prem_next : partial remainder after the step
//   q_bit     : quotient bit produced by the step
module div_step #(
    parameter int VW = 8
) (
    input  logic [VW-1:0] prem,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] prem_next,
    output logic          q_bit
);
    logic [VW:0] shifted;
    logic [VW:0] trial;
    // Restoring keeps prem below the divisor, so VW bits hold it between
    // steps; only the shifted trial value needs the extra sign bit.
    assign shifted   = {prem, bit_in};
    assign trial     = shifted - {1'b0, divisor};
    assign q_bit     = ~trial[VW];
    assign prem_next = q_bit ? trial[VW-1:0] : shifted[VW-1:0];
endmodule

// File: rtl/hex_divider.sv
// hex_divider: sequential unsigned restoring divider, one quotient bit per clock
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of hex_divider_if (operands, start/enable, results, busy/done)
module hex_divider
    import hex_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input logic         clk,
    input logic         rst,
    hex_divider_if.slave bus
);
    localparam int CW = cnt_w(DW);
    state_t        state, state_nxt;
    logic          accept;
    logic [DW-1:0] dq;
    logic [VW-1:0] divisor;
    logic [VW-1:0] prem;
    logic [VW-1:0] prem_next;
    logic          q_bit;
    logic [CW-1:0] cnt;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          busy;
    logic          done;

    div_step #(.VW(VW)) u_step (
        .prem      (prem),
        .bit_in    (dq[DW-1]),
        .divisor   (divisor),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = state == IDLE && bus.enable && bus.start;
        if (accept) state_nxt = bus.in_2 == '0 ? DONE : DIVIDE;
        else if (state == DIVIDE && cnt == CW'(DW - 1)) state_nxt = DONE;
        else if (state == DONE) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dq          <= '0;
            divisor     <= '0;
            prem        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                dq          <= bus.in_1;
                divisor     <= bus.in_2;
                prem        <= '0;
                cnt         <= '0;
                div_by_zero <= 1'b0;
                busy        <= 1'b1;
            end else if (state == DIVIDE) begin
                dq   <= {dq[DW-2:0], q_bit};
                prem <= prem_next;
                cnt  <= cnt + CW'(1);
            end else if (state == DONE) begin
                // A zero divisor skipped DIVIDE, so dq still holds the dividend.
                done        <= 1'b1;
                quotient    <= divisor == '0 ? '1 : dq;
                remainder   <= divisor == '0 ? dq[VW-1:0] : prem;
                div_by_zero <= divisor == '0;
            end else if (done) begin
                busy <= 1'b0;
            end
        end
    end

    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;
    assign bus.busy        = busy;
    assign bus.done        = done;
endmodule

// File: tb/tb_hex_divider.sv
// tb_hex_divider: scoreboard bench for hex_divider
module tb_hex_divider;
    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    hex_divider_if #(.DW(16), .VW(8)) bus ();

    hex_divider #(.DW(16), .VW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 32'(bus.quotient), 32'(e.q));
                chk("remainder", 32'(bus.remainder), 32'(e.r));
                chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
                chk("latency", 32'(cyc), 32'(e.due));
                chk("busy_at_done", 32'(bus.busy), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        bus.in_1   = a;
        bus.in_2   = b;
        bus.enable = 1'b1;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.enable = 1'b0;
        bus.in_1   = ~a;
        bus.in_2   = ~b;
        e.q   = b == 0 ? 16'hFFFF : a / 16'(b);
        e.r   = b == 0 ? a[7:0] : 8'(a % 16'(b));
        e.dz  = b == 0;
        e.due = cyc + (b == 0 ? 1 : 17);
        sb.push_back(e);
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            chk("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        tick();
        chk("busy_cleared", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.start  = 1'b0;
        bus.in_1   = '0;
        bus.in_2   = '0;
        repeat (2) tick();
        chk("rst_quotient", 32'(bus.quotient), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        tick();

        run(16'h1234, 8'h12); wait_done();
        run(16'hFFFF, 8'h01); wait_done();
        run(16'hFFFF, 8'hFF); wait_done();
        run(16'h0005, 8'h07); wait_done();
        run(16'hABCD, 8'h00); wait_done();
        run(16'h8001, 8'h80); wait_done();
        for (int k = 0; k < 6; k++) begin
            run(16'($urandom), 8'($urandom_range(0, 255)));
            wait_done();
        end

        run(16'h1234, 8'h12);
        repeat (4) tick();
        bus.in_1   = 16'h0010;
        bus.in_2   = 8'h02;
        bus.enable = 1'b1;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.enable = 1'b0;
        wait_done();

        bus.in_1   = 16'h0050;
        bus.in_2   = 8'h05;
        bus.enable = 1'b0;
        bus.start  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("gated_busy", 32'(bus.busy), 32'd0);
        end
        bus.start = 1'b0;
        repeat (20) tick();

        run(16'h1234, 8'h12);
        repeat (7) tick();
        void'(sb.pop_back());
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_quotient", 32'(bus.quotient), 32'd0);
        chk("mid_rst_remainder", 32'(bus.remainder), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        repeat (20) tick();
        run(16'h0064, 8'h0A); wait_done();

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
